axi_lite_regfile: RTL and testbench

AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

---
 rtl/axi_lite_pkg.sv | 17 +
 rtl/axi_lite_reg_bank.sv | 37 +++
 rtl/axi_lite_regfile.sv | 199 +++++++++++++++++++
 tb/tb_axi_lite_regfile.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared response codes and handshake FSM state encodings for the AXI-Lite register file.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/axi_lite_reg_bank.sv
// Register storage: byte-strobed synchronous write port, asynchronous read port, async clear.
module axi_lite_reg_bank #(
    parameter int unsigned REG_NUM = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned IDX_W   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_W-1:0]     rdata_c
);

    localparam int unsigned NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [REG_NUM];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave exposing REG_NUM 32-bit registers; independent write and read handshake FSMs.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned REG_NUM        = 16,
    parameter logic [31:0] BASE_ADDR      = 32'h0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [AXI_ADDR_WIDTH-1:0]   i_awaddr,
    input  logic                        i_awvalid,
    output logic                        o_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   i_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                        i_wvalid,
    output logic                        o_wready,
    output logic [1:0]                  o_bresp,
    output logic                        o_bvalid,
    input  logic                        i_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   i_araddr,
    input  logic                        i_arvalid,
    output logic                        o_arready,
    output logic [AXI_DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]                  o_rresp,
    output logic                        o_rvalid,
    input  logic                        i_rready
);

    localparam int unsigned IDX_W  = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam logic [AXI_ADDR_WIDTH-1:0] BASE_A    = AXI_ADDR_WIDTH'(BASE_ADDR);
    localparam logic [AXI_ADDR_WIDTH-1:0] REGION_SZ = AXI_ADDR_WIDTH'(REG_NUM * 4);

    function automatic logic addr_ok(input logic [AXI_ADDR_WIDTH-1:0] a);
        logic [AXI_ADDR_WIDTH-1:0] off;
        off = a - BASE_A;
        return (a >= BASE_A) && (off < REGION_SZ);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_A) >> 2);
    endfunction

    w_state_e w_state, w_state_n;
    r_state_e r_state, r_state_n;

    logic                      aw_held, aw_held_n, w_held, w_held_n;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_n;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_n;
    logic [STRB_W-1:0]         wstrb_q, wstrb_n;
    logic                      awready_q, awready_n, wready_q, wready_n;
    logic                      bvalid_q, bvalid_n;
    logic [1:0]                bresp_q, bresp_n;
    logic                      arready_q, arready_n, rvalid_q, rvalid_n;
    logic [1:0]                rresp_q, rresp_n;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_n;

    logic                      aw_hs, w_hs;
    logic [AXI_ADDR_WIDTH-1:0] cur_awaddr;
    logic [AXI_DATA_WIDTH-1:0] cur_wdata;
    logic [STRB_W-1:0]         cur_wstrb;
    logic                      bank_we_c;
    logic [AXI_DATA_WIDTH-1:0] bank_rdata_c;

    axi_lite_reg_bank #(
        .REG_NUM (REG_NUM),
        .DATA_W  (AXI_DATA_WIDTH),
        .IDX_W   (IDX_W)
    ) u_bank (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .we      (bank_we_c),
        .waddr   (addr_idx(cur_awaddr)),
        .wdata   (cur_wdata),
        .wstrb   (cur_wstrb),
        .raddr   (addr_idx(i_araddr)),
        .rdata_c (bank_rdata_c)
    );

    // Write path: collect AW and W in any order, commit on the edge both are present.
    always_comb begin
        w_state_n  = w_state;
        aw_held_n  = aw_held;
        w_held_n   = w_held;
        aw_addr_n  = aw_addr_q;
        wdata_n    = wdata_q;
        wstrb_n    = wstrb_q;
        bvalid_n   = bvalid_q;
        bresp_n    = bresp_q;
        bank_we_c  = 1'b0;
        aw_hs      = i_awvalid & awready_q;
        w_hs       = i_wvalid & wready_q;
        cur_awaddr = aw_held ? aw_addr_q : i_awaddr;
        cur_wdata  = w_held ? wdata_q : i_wdata;
        cur_wstrb  = w_held ? wstrb_q : i_wstrb;
        case (w_state)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_n = 1'b1;
                    aw_addr_n = i_awaddr;
                end
                if (w_hs) begin
                    w_held_n = 1'b1;
                    wdata_n  = i_wdata;
                    wstrb_n  = i_wstrb;
                end
                if ((aw_held | aw_hs) && (w_held | w_hs)) begin
                    w_state_n = W_RESP;
                    bvalid_n  = 1'b1;
                    bank_we_c = addr_ok(cur_awaddr);
                    bresp_n   = addr_ok(cur_awaddr) ? RESP_OKAY : RESP_SLVERR;
                end
            end
            W_RESP: begin
                if (i_bready) begin
                    w_state_n = W_IDLE;
                    bvalid_n  = 1'b0;
                    aw_held_n = 1'b0;
                    w_held_n  = 1'b0;
                end
            end
        endcase
        awready_n = (w_state_n == W_IDLE) && !aw_held_n;
        wready_n  = (w_state_n == W_IDLE) && !w_held_n;
    end

    // Read path: sample the bank on the AR edge so a same-edge write is not visible yet.
    always_comb begin
        r_state_n = r_state;
        rvalid_n  = rvalid_q;
        rdata_n   = rdata_q;
        rresp_n   = rresp_q;
        case (r_state)
            R_IDLE: begin
                if (i_arvalid && arready_q) begin
                    r_state_n = R_DATA;
                    rvalid_n  = 1'b1;
                    rdata_n   = addr_ok(i_araddr) ? bank_rdata_c : '0;
                    rresp_n   = addr_ok(i_araddr) ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA: begin
                if (i_rready) begin
                    r_state_n = R_IDLE;
                    rvalid_n  = 1'b0;
                end
            end
        endcase
        arready_n = (r_state_n == R_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            w_state   <= W_IDLE;
            r_state   <= R_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            w_state   <= w_state_n;
            r_state   <= r_state_n;
            aw_held   <= aw_held_n;
            w_held    <= w_held_n;
            aw_addr_q <= aw_addr_n;
            wdata_q   <= wdata_n;
            wstrb_q   <= wstrb_n;
            awready_q <= awready_n;
            wready_q  <= wready_n;
            bvalid_q  <= bvalid_n;
            bresp_q   <= bresp_n;
            arready_q <= arready_n;
            rvalid_q  <= rvalid_n;
            rresp_q   <= rresp_n;
            rdata_q   <= rdata_n;
        end
    end

    assign o_awready = awready_q;
    assign o_wready  = wready_q;
    assign o_bvalid  = bvalid_q;
    assign o_bresp   = bresp_q;
    assign o_arready = arready_q;
    assign o_rvalid  = rvalid_q;
    assign o_rresp   = rresp_q;
    assign o_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile: vector table of single transactions plus multi-cycle sequences.
module tb_axi_lite_regfile;

    logic        i_clk, i_rst;
    logic [31:0] i_awaddr, i_wdata, i_araddr;
    logic        i_awvalid, i_wvalid, i_bready, i_arvalid, i_rready;
    logic [3:0]  i_wstrb;
    logic        o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
    logic [1:0]  o_bresp, o_rresp;
    logic [31:0] o_rdata;

    axi_lite_regfile dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_awaddr  (i_awaddr),
        .i_awvalid (i_awvalid),
        .o_awready (o_awready),
        .i_wdata   (i_wdata),
        .i_wstrb   (i_wstrb),
        .i_wvalid  (i_wvalid),
        .o_wready  (o_wready),
        .o_bresp   (o_bresp),
        .o_bvalid  (o_bvalid),
        .i_bready  (i_bready),
        .i_araddr  (i_araddr),
        .i_arvalid (i_arvalid),
        .o_arready (o_arready),
        .o_rdata   (o_rdata),
        .o_rresp   (o_rresp),
        .o_rvalid  (o_rvalid),
        .i_rready  (i_rready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // sel 0: AW and W ready; sel 1: AR ready
    task automatic wait_ready(input string name, input int sel);
        logic ok;
        ok = (sel == 0) ? (o_awready & o_wready) : o_arready;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick;
            ok = (sel == 0) ? (o_awready & o_wready) : o_arready;
        end
        check({name, "_ready"}, 32'(ok), 32'd1);
    endtask

    task automatic do_write(input string name, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
        wait_ready(name, 0);
        i_awaddr = addr; i_awvalid = 1'b1;
        i_wdata = data; i_wstrb = strb; i_wvalid = 1'b1;
        tick;
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        check({name, "_bvalid"}, 32'(o_bvalid), 32'd1);
        check({name, "_bresp"}, 32'(o_bresp), 32'(exp_resp));
        i_bready = 1'b1;
        tick;
        i_bready = 1'b0;
        check({name, "_bdone"}, 32'(o_bvalid), 32'd0);
    endtask

    task automatic do_read(input string name, input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
        wait_ready(name, 1);
        i_araddr = addr; i_arvalid = 1'b1;
        tick;
        i_arvalid = 1'b0;
        check({name, "_rvalid"}, 32'(o_rvalid), 32'd1);
        check({name, "_rdata"}, o_rdata, exp_data);
        check({name, "_rresp"}, 32'(o_rresp), 32'(exp_resp));
        i_rready = 1'b1;
        tick;
        i_rready = 1'b0;
        check({name, "_rdone"}, 32'(o_rvalid), 32'd0);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_readies"}, 32'({o_awready, o_wready, o_arready}), 32'd0);
        check({name, "_valids"}, 32'({o_bvalid, o_rvalid}), 32'd0);
        check({name, "_resps"}, 32'({o_bresp, o_rresp}), 32'd0);
        check({name, "_rdata"}, o_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 2'b00};
        vecs[1]  = '{1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 4'h0, 2'b00};
        vecs[2]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF, 2'b00};
        vecs[3]  = '{1'b1, 32'h0000_003C, 32'h0102_0304, 4'b1000, 2'b00};
        vecs[4]  = '{1'b0, 32'h0000_003C, 32'h0100_0000, 4'h0, 2'b00};
        vecs[5]  = '{1'b0, 32'h0000_003F, 32'h0100_0000, 4'h0, 2'b00};
        vecs[6]  = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'hF, 2'b10};
        vecs[7]  = '{1'b0, 32'h0000_0040, 32'h0000_0000, 4'h0, 2'b10};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'hA5A5_A5A5, 4'h0, 2'b00};
        vecs[9]  = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF, 2'b00};
        vecs[10] = '{1'b1, 32'hFFFF_FFFC, 32'h1111_1111, 4'hF, 2'b10};
        vecs[11] = '{1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 4'h0, 2'b00};

        i_rst = 1'b1;
        i_awaddr = '0; i_awvalid = 1'b0; i_wdata = '0; i_wstrb = '0; i_wvalid = 1'b0;
        i_bready = 1'b0; i_araddr = '0; i_arvalid = 1'b0; i_rready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check_idle_outputs("reset");
        i_rst = 1'b0;
        tick;
        check("post_reset_readies", 32'({o_awready, o_wready, o_arready}), 32'h7);

        foreach (vecs[i]) begin
            if (vecs[i].wr)
                do_write($sformatf("vec%0d_wr", i), vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
            else
                do_read($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].data, vecs[i].resp);
        end

        // W three cycles ahead of AW, partial strobe over an all-ones register
        wait_ready("wfirst", 0);
        i_wdata = 32'h1234_5678; i_wstrb = 4'b0101; i_wvalid = 1'b1;
        tick;
        i_wvalid = 1'b0;
        check("wfirst_wready_low", 32'(o_wready), 32'd0);
        check("wfirst_awready_high", 32'(o_awready), 32'd1);
        repeat (2) begin
            tick;
            check("wfirst_wait_wready", 32'(o_wready), 32'd0);
            check("wfirst_wait_bvalid", 32'(o_bvalid), 32'd0);
        end
        i_awaddr = 32'h4; i_awvalid = 1'b1;
        tick;
        i_awvalid = 1'b0;
        check("wfirst_bvalid", 32'(o_bvalid), 32'd1);
        check("wfirst_bresp", 32'(o_bresp), 32'd0);
        check("wfirst_readies_in_resp", 32'({o_awready, o_wready}), 32'd0);
        i_bready = 1'b1;
        tick;
        i_bready = 1'b0;
        check("wfirst_bdone", 32'(o_bvalid), 32'd0);
        check("wfirst_readies_back", 32'({o_awready, o_wready}), 32'h3);
        do_read("wfirst_rd", 32'h4, 32'hFF34_FF78, 2'b00);

        // Back-pressure on both response channels
        wait_ready("stall_w", 0);
        wait_ready("stall_r", 1);
        i_awaddr = 32'h10; i_awvalid = 1'b1;
        i_wdata = 32'hCAFE_F00D; i_wstrb = 4'hF; i_wvalid = 1'b1;
        i_araddr = 32'h8; i_arvalid = 1'b1;
        tick;
        i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_valids", 32'({o_bvalid, o_rvalid}), 32'h3);
            check("stall_bresp", 32'(o_bresp), 32'd0);
            check("stall_rdata", o_rdata, 32'hDEAD_BEEF);
            check("stall_rresp", 32'(o_rresp), 32'd0);
            check("stall_readies", 32'({o_awready, o_wready, o_arready}), 32'd0);
            tick;
        end
        i_bready = 1'b1; i_rready = 1'b1;
        tick;
        i_bready = 1'b0; i_rready = 1'b0;
        check("stall_done", 32'({o_bvalid, o_rvalid}), 32'd0);

        // Same-edge write commit and read of one register returns the old value
        do_write("same_w1", 32'hC, 32'h1, 4'hF, 2'b00);
        wait_ready("same_w", 0);
        wait_ready("same_r", 1);
        i_awaddr = 32'hC; i_awvalid = 1'b1;
        i_wdata = 32'h2; i_wstrb = 4'hF; i_wvalid = 1'b1;
        i_araddr = 32'hC; i_arvalid = 1'b1;
        tick;
        i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
        check("same_valids", 32'({o_bvalid, o_rvalid}), 32'h3);
        check("same_rdata_old", o_rdata, 32'h1);
        i_bready = 1'b1; i_rready = 1'b1;
        tick;
        i_bready = 1'b0; i_rready = 1'b0;
        do_read("same_rd_new", 32'hC, 32'h2, 2'b00);

        // Reset asserted with both channels mid-response
        wait_ready("rst_w", 0);
        wait_ready("rst_r", 1);
        i_awaddr = 32'h10; i_awvalid = 1'b1;
        i_wdata = 32'h55; i_wstrb = 4'hF; i_wvalid = 1'b1;
        i_araddr = 32'h10; i_arvalid = 1'b1;
        tick;
        i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
        check("rst_pre_valids", 32'({o_bvalid, o_rvalid}), 32'h3);
        check("rst_pre_rdata", o_rdata, 32'hCAFE_F00D);
        i_rst = 1'b1;
        #1;
        check_idle_outputs("rst_mid");
        tick;
        tick;
        check_idle_outputs("rst_held");
        i_rst = 1'b0;
        tick;
        check("rst_release_readies", 32'({o_awready, o_wready, o_arready}), 32'h7);
        check("rst_release_valids", 32'({o_bvalid, o_rvalid}), 32'd0);
        for (int r = 0; r < 16; r++) begin
            do_read($sformatf("rst_clear_r%0d", r), 32'(r * 4), 32'd0, 2'b00);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
